// File: rtl/adder_serial_nbits.sv
// adder_serial_nbits: CHUNK-bits-per-cycle serial adder/subtractor with valid/ready handshakes
module adder_serial_nbits #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] first_word,
  input  logic [WIDTH-1:0] second_word,
  input  logic             carry_in,
  input  logic             sub_mode,
  output logic [WIDTH-1:0] sum_word,
  output logic             carry_out,
  output logic             overflow,
  output logic             done_valid,
  input  logic             done_ready
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_nx;
  logic [CW-1:0] cnt;
  logic [CHUNK:0] slice;
  logic carry_q, last;
  always_comb begin
    slice = {1'b0, a_q[cnt*CHUNK +: CHUNK]} + {1'b0, b_q[cnt*CHUNK +: CHUNK]} + (CHUNK+1)'(carry_q);
    acc_nx = acc;
    acc_nx[cnt*CHUNK +: CHUNK] = slice[CHUNK-1:0];
    last = cnt == CW'(N - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      carry_q     <= 1'b0;
      cnt         <= '0;
      sum_word    <= '0;
      carry_out   <= 1'b0;
      overflow    <= 1'b0;
      done_valid  <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          a_q         <= first_word;
          b_q         <= sub_mode ? ~second_word : second_word;
          carry_q     <= sub_mode | carry_in;
          cnt         <= '0;
          acc         <= '0;
          start_ready <= 1'b0;
          state       <= RUN;
        end
        RUN: begin
          acc     <= acc_nx;
          carry_q <= slice[CHUNK];
          cnt     <= cnt + 1'b1;
          if (last) begin
            // carry into the MSB is recovered as a^b^sum of that bit
            sum_word   <= acc_nx;
            carry_out  <= slice[CHUNK];
            overflow   <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ acc_nx[WIDTH-1] ^ slice[CHUNK];
            done_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: if (done_ready) begin
          done_valid  <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_serial_nbits.sv
// tb_adder_serial_nbits: directed vector bench for the serial adder (WIDTH=16, CHUNK=4)
module tb_adder_serial_nbits;
  logic clk = 1'b0, rst = 1'b1;
  logic start_valid = 1'b0, carry_in = 1'b0, sub_mode = 1'b0, done_ready = 1'b0;
  logic [15:0] first_word = '0, second_word = '0;
  logic start_ready, carry_out, overflow, done_valid;
  logic [15:0] sum_word;
  int checks = 0, errors = 0;

  adder_serial_nbits #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .first_word(first_word), .second_word(second_word), .carry_in(carry_in),
    .sub_mode(sub_mode), .sum_word(sum_word), .carry_out(carry_out),
    .overflow(overflow), .done_valid(done_valid), .done_ready(done_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a, b;
    logic        ci, sub;
    logic [15:0] sum;
    logic        co, ov;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sub);
    first_word = a; second_word = b; carry_in = ci; sub_mode = sub; start_valid = 1'b1;
    chk("start_ready_before_accept", 32'(start_ready), 32'd1);
    step();
    start_valid = 1'b0;
    first_word = 16'hDEAD; second_word = 16'hBEEF; carry_in = ~ci; sub_mode = ~sub;
  endtask

  task automatic wait_done(input string name);
    logic [15:0] pre;
    int n;
    bit stable;
    pre = sum_word; n = 0; stable = 1'b1;
    while (n < 20) begin
      step();
      n++;
      if (done_valid) break;
      if (sum_word !== pre || start_ready !== 1'b0) stable = 1'b0;
    end
    chk({name, "_latency"}, 32'(n), 32'd4);
    chk({name, "_run_stable"}, 32'(stable), 32'd1);
  endtask

  task automatic chk_res(input string name, input logic [15:0] s, input logic co, input logic ov);
    chk({name, "_sum"}, 32'(sum_word), 32'(s));
    chk({name, "_carry"}, 32'(carry_out), 32'(co));
    chk({name, "_ovf"}, 32'(overflow), 32'(ov));
  endtask

  task automatic release_done(input string name);
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk({name, "_idle_ready"}, 32'(start_ready), 32'd1);
    chk({name, "_idle_valid"}, 32'(done_valid), 32'd0);
  endtask

  initial begin
    vec_t v[8];
    v[0] = '{"add_basic", 16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0};
    v[1] = '{"add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[2] = '{"add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[3] = '{"add_negov", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    v[4] = '{"sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    v[5] = '{"sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    v[6] = '{"sub_ci_ign",16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    v[7] = '{"add_mixed", 16'hA5A5, 16'h5A5B, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk_res("rst", 16'h0000, 1'b0, 1'b0);
    step(); step();
    chk("idle_hold_ready", 32'(start_ready), 32'd1);
    chk("idle_hold_valid", 32'(done_valid), 32'd0);
    chk_res("idle_hold", 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      accept(v[i].a, v[i].b, v[i].ci, v[i].sub);
      wait_done(v[i].name);
      chk_res(v[i].name, v[i].sum, v[i].co, v[i].ov);
      release_done(v[i].name);
    end

    // backpressure with a pending request waiting behind the result
    accept(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_done("bp_first");
    first_word = 16'h0100; second_word = 16'h0200; carry_in = 1'b0; sub_mode = 1'b0;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_held", 32'(done_valid), 32'd1);
      chk("bp_ready_low", 32'(start_ready), 32'd0);
      chk_res("bp_hold", 16'h3333, 1'b0, 1'b0);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk("bp_release_ready", 32'(start_ready), 32'd1);
    chk("bp_release_valid", 32'(done_valid), 32'd0);
    step();
    start_valid = 1'b0;
    chk("bp_accepted", 32'(start_ready), 32'd0);
    wait_done("bp_second");
    chk_res("bp_second", 16'h0300, 1'b0, 1'b0);
    release_done("bp_second");

    // reset after two RUN edges aborts the operation
    accept(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", 32'(start_ready), 32'd1);
    chk("mid_rst_valid", 32'(done_valid), 32'd0);
    chk_res("mid_rst", 16'h0000, 1'b0, 1'b0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (done_valid) seen = 1'b1;
      end
      chk("mid_rst_no_done", 32'(seen), 32'd0);
    end
    accept(16'h0001, 16'h0002, 1'b0, 1'b0);
    wait_done("post_rst");
    chk_res("post_rst", 16'h0003, 1'b0, 1'b0);
    release_done("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
